// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner: FSM state encoding,
// the SoP block's reference minterm mask and the default settle time.
package scanner_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_e;

    // f = m(2, 4, 7, 11, 12) of the 4-input SoP block
    localparam logic [15:0] SOP_MINTERMS = 16'h1894;

    localparam int SETTLE_DEFAULT = 1;

    // Counter width able to hold n-1 (at least one bit)
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// settle_timer: down-counter that holds the scanner in WAIT for SETTLE
// cycles. load_i reloads SETTLE-1, en_i counts down, expire_o flags zero.
module settle_timer
    import scanner_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = cnt_width(SETTLE);
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: reload has priority, then decrement until zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: sweeps all 2^N_IN minterms into the function under
// test, captures its output s per minterm into table_out and compares the
// result against EXPECTED. Optional macro SCAN_ERRCNT_EN adds err_count,
// the number of minterms whose captured value differs from EXPECTED.
module truth_table_scanner
    import scanner_pkg::*;
#(
    parameter int                    N_IN     = 4,
    parameter int                    SETTLE   = SETTLE_DEFAULT,
    parameter logic [(1<<N_IN)-1:0]  EXPECTED = SOP_MINTERMS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [N_IN-1:0]      vec,
    input  logic                 s,
    output logic                 busy,
    output logic                 done,
    output logic [(1<<N_IN)-1:0] table_out,
    output logic                 match
`ifdef SCAN_ERRCNT_EN
    ,
    output logic [N_IN:0]        err_count
`endif
);

    localparam int TW = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = '1;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   idx_q,   idx_d;
    logic [TW-1:0]     table_q, table_d;
    logic              match_q, match_d;
`ifdef SCAN_ERRCNT_EN
    logic [N_IN:0]     err_q,   err_d;
`endif

    logic timer_load;
    logic timer_en;
    logic timer_expire;

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (timer_load),
        .en_i     (timer_en),
        .expire_o (timer_expire)
    );

    // Next-state, index, capture and compare logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        table_d    = table_q;
        match_d    = match_q;
        timer_load = 1'b0;
        timer_en   = 1'b0;
`ifdef SCAN_ERRCNT_EN
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d      = '0;
                    table_d    = '0;
                    match_d    = 1'b0;
                    timer_load = 1'b1;
`ifdef SCAN_ERRCNT_EN
                    err_d      = '0;
`endif
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (timer_expire) begin
                    state_d = SAMPLE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            SAMPLE: begin
                table_d[idx_q] = s;
`ifdef SCAN_ERRCNT_EN
                if (s != EXPECTED[idx_q]) begin
                    err_d = err_q + 1'b1;
                end
`endif
                if (idx_q == LAST_IDX) begin
                    // Compare on the completed table so match is valid with done
                    match_d = (table_d == EXPECTED);
                    state_d = FINISH;
                end else begin
                    idx_d      = idx_q + 1'b1;
                    timer_load = 1'b1;
                    state_d    = WAIT;
                end
            end
            FINISH: begin
                match_d = (table_q == EXPECTED);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            table_q <= '0;
            match_q <= 1'b0;
`ifdef SCAN_ERRCNT_EN
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            table_q <= table_d;
            match_q <= match_d;
`ifdef SCAN_ERRCNT_EN
            err_q   <= err_d;
`endif
        end
    end

    // vec is the index register itself, so it holds its last minterm when idle
    assign vec       = idx_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign table_out = table_q;
    assign match     = match_q;
`ifdef SCAN_ERRCNT_EN
    assign err_count = err_q;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: a SETTLE=1 instance driven by a selectable
// stimulus (SoP block, constant 0/1, AND of inputs) and a SETTLE=3 instance
// whose s follows vec[0].
module tb_truth_table_scanner;

    logic        clk;
    logic        reset;
    logic        start1, start3;
    logic [1:0]  mode;
    logic [3:0]  vec1, vec3;
    logic        s1, s3;
    logic        busy1, busy3, done1, done3, match1, match3;
    logic [15:0] tab1, tab3;
`ifdef SCAN_ERRCNT_EN
    logic [4:0]  err1, err3;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [1:0]  mode;
        bit          use3;
        logic [15:0] exp_tab;
        logic        exp_match;
        int          exp_err;
        int          exp_done;
    } vec_t;

    vec_t vt[5];

    function automatic logic sop(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return (!a && !b &&  c && !d) ||
               (!a &&  b && !c && !d) ||
               (!a &&  b &&  c &&  d) ||
               ( a && !b &&  c &&  d) ||
               ( a &&  b && !c && !d);
    endfunction

    always_comb begin
        s1 = 1'b0;
        case (mode)
            2'd0: s1 = sop(vec1);
            2'd1: s1 = 1'b0;
            2'd2: s1 = &vec1;
            2'd3: s1 = 1'b1;
            default: s1 = 1'b0;
        endcase
    end

    assign s3 = vec3[0];

    truth_table_scanner dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start1),
        .vec       (vec1),
        .s         (s1),
        .busy      (busy1),
        .done      (done1),
        .table_out (tab1),
        .match     (match1)
`ifdef SCAN_ERRCNT_EN
        ,
        .err_count (err1)
`endif
    );

    truth_table_scanner #(.SETTLE(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .start     (start3),
        .vec       (vec3),
        .s         (s3),
        .busy      (busy3),
        .done      (done3),
        .table_out (tab3),
        .match     (match3)
`ifdef SCAN_ERRCNT_EN
        ,
        .err_count (err3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Accepts start at edge 0 and returns the cycle in which done is seen
    task automatic run_sweep(input bit use3, input int inject_at,
                             output int dcyc, output bit busy_ok);
        int  n;
        bit  injected;
        injected = 1'b0;
        busy_ok  = 1'b1;
        dcyc     = -1;
        if (use3) start3 = 1'b1; else start1 = 1'b1;
        step();
        start1 = 1'b0;
        start3 = 1'b0;
        n = 1;
        while (n < 200) begin
            if (!(use3 ? busy3 : busy1)) busy_ok = 1'b0;
            if (use3 ? done3 : done1) begin
                dcyc = n;
                break;
            end
            if (!injected && inject_at >= 0 && vec1 == inject_at[3:0]) begin
                start1   = 1'b1;
                injected = 1'b1;
            end
            step();
            start1 = 1'b0;
            n++;
        end
    endtask

    initial begin
        int  dcyc;
        bit  bok;
        int  dts[3];
        logic mts[3];
        int  nd;
        bit  saw;

        vt[0] = '{"sop",   2'd0, 1'b0, 16'h1894, 1'b1, 0,  33};
        vt[1] = '{"zero",  2'd1, 1'b0, 16'h0000, 1'b0, 5,  33};
        vt[2] = '{"and",   2'd2, 1'b0, 16'h8000, 1'b0, 6,  33};
        vt[3] = '{"one",   2'd3, 1'b0, 16'hFFFF, 1'b0, 11, 33};
        vt[4] = '{"s3_d",  2'd0, 1'b1, 16'hAAAA, 1'b0, 9,  65};

        reset  = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        mode   = 2'd0;
        step();
        step();
        reset = 1'b0;

        chk("rst_vec",   {28'd0, vec1}, 32'd0);
        chk("rst_busy",  {31'd0, busy1}, 32'd0);
        chk("rst_done",  {31'd0, done1}, 32'd0);
        chk("rst_table", {16'd0, tab1}, 32'd0);
        chk("rst_match", {31'd0, match1}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            mode = vt[i].mode;
            do_reset();
            run_sweep(vt[i].use3, -1, dcyc, bok);
            chk({vt[i].name, "_done_cycle"}, dcyc, vt[i].exp_done);
            chk({vt[i].name, "_busy"}, {31'd0, bok}, 32'd1);
            chk({vt[i].name, "_table"}, {16'd0, (vt[i].use3 ? tab3 : tab1)}, {16'd0, vt[i].exp_tab});
            chk({vt[i].name, "_match"}, {31'd0, (vt[i].use3 ? match3 : match1)}, {31'd0, vt[i].exp_match});
`ifdef SCAN_ERRCNT_EN
            chk({vt[i].name, "_err"}, {27'd0, (vt[i].use3 ? err3 : err1)}, vt[i].exp_err);
`endif
            step();
            chk({vt[i].name, "_done_pulse"}, {31'd0, (vt[i].use3 ? done3 : done1)}, 32'd0);
            chk({vt[i].name, "_idle"}, {31'd0, (vt[i].use3 ? busy3 : busy1)}, 32'd0);
            chk({vt[i].name, "_hold"}, {16'd0, (vt[i].use3 ? tab3 : tab1)}, {16'd0, vt[i].exp_tab});
        end

        // Reset in the middle of a sweep
        mode = 2'd0;
        do_reset();
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int n = 0; n < 40 && vec1 != 4'd7; n++) step();
        chk("abort_reach_idx7", {28'd0, vec1}, 32'd7);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy",  {31'd0, busy1}, 32'd0);
        chk("abort_vec",   {28'd0, vec1}, 32'd0);
        chk("abort_table", {16'd0, tab1}, 32'd0);
        saw = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (done1) saw = 1'b1;
            step();
        end
        chk("abort_no_done", {31'd0, saw}, 32'd0);
        run_sweep(1'b0, -1, dcyc, bok);
        chk("abort_rerun_cycle", dcyc, 33);
        chk("abort_rerun_table", {16'd0, tab1}, 32'h1894);
        chk("abort_rerun_match", {31'd0, match1}, 32'd1);

        // start pulsed during WAIT at idx=3 must be ignored
        do_reset();
        run_sweep(1'b0, 3, dcyc, bok);
        chk("ignore_done_cycle", dcyc, 33);
        chk("ignore_busy", {31'd0, bok}, 32'd1);
        chk("ignore_table", {16'd0, tab1}, 32'h1894);

        // start held high: back-to-back sweeps every 34 cycles
        do_reset();
        start1 = 1'b1;
        step();
        nd = 0;
        for (int n = 1; n < 150 && nd < 3; n++) begin
            if (done1) begin
                dts[nd] = n;
                mts[nd] = match1;
                nd++;
            end
            step();
        end
        start1 = 1'b0;
        chk("cont_count", nd, 3);
        if (nd == 3) begin
            chk("cont_done0", dts[0], 33);
            chk("cont_done1", dts[1], 67);
            chk("cont_done2", dts[2], 101);
            for (int k = 0; k < 3; k++) chk("cont_match", {31'd0, mts[k]}, 32'd1);
        end
        for (int n = 0; n < 80 && busy1; n++) step();
        chk("cont_drain", {31'd0, busy1}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
